// File: rtl/control_sequencer.sv
// control_sequencer
//   Fetch/execute controller for the 8-bit shared-bus machine. A T-state
//   counter (IDLE, T1..T6, HALT) advances on the falling edge of clk so the
//   control word is settled before the rising edge on which the datapath
//   registers load. The control word is decoded combinationally from the
//   current state and the IR opcode nibble.
//
// Ports
//   clk            system clock (state advances on falling edge)
//   clr_bar        asynchronous active-low clear
//   run            start/continue request, sampled in IDLE and at end of
//                  each instruction
//   opcode[3:0]    IR upper nibble, valid from T4 onward
//   pc_clr, load_pc, pc_inc, enable_pc          PC controls (active-high)
//   load_mar_bar                                MAR load (active-low)
//   ram_read_bar, ram_write_bar, enable_ram_bar RAM controls (active-low)
//   load_ir_bar, enable_ir_bar                  IR controls (active-low)
//   load_a_bar, enable_a_bar, load_b_bar, enable_b_bar  A/B controls
//   add_sub_bar    ALU mode, 1 = add, 0 = subtract
//   enable_alu_bar ALU bus drive (active-low)
//   load_out_bar   output register load (active-low)
//   t_state[5:0]   one-hot T1..T6, zero in IDLE/HALT
//   halted         high while in HALT
module control_sequencer #(
    parameter bit         EARLY_END = 1'b0,
    parameter logic [3:0] OP_LDA    = 4'b0000,
    parameter logic [3:0] OP_ADD    = 4'b0001,
    parameter logic [3:0] OP_SUB    = 4'b0010,
    parameter logic [3:0] OP_STA    = 4'b0011,
    parameter logic [3:0] OP_JMP    = 4'b0100,
    parameter logic [3:0] OP_OUT    = 4'b1110,
    parameter logic [3:0] OP_HLT    = 4'b1111
) (
    input  logic       clk,
    input  logic       clr_bar,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic       pc_clr,
    output logic       load_pc,
    output logic       pc_inc,
    output logic       enable_pc,
    output logic       load_mar_bar,
    output logic       ram_read_bar,
    output logic       ram_write_bar,
    output logic       enable_ram_bar,
    output logic       load_ir_bar,
    output logic       enable_ir_bar,
    output logic       load_a_bar,
    output logic       enable_a_bar,
    output logic       load_b_bar,
    output logic       enable_b_bar,
    output logic       add_sub_bar,
    output logic       enable_alu_bar,
    output logic       load_out_bar,
    output logic [5:0] t_state,
    output logic       halted
);

    typedef enum logic [2:0] {
        S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t state, state_nx;
    logic   last_state;
    logic   is_nop;

    assign is_nop = !(opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB ||
                      opcode == OP_STA || opcode == OP_JMP || opcode == OP_OUT ||
                      opcode == OP_HLT);

    // Falling-edge state register: control word settles half a cycle
    // ahead of the datapath's rising-edge loads.
    always_ff @(negedge clk or negedge clr_bar) begin
        if (!clr_bar) state <= S_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        last_state = 1'b0;
        case (state)
            S_IDLE: state_nx = run ? S_T1 : S_IDLE;
            S_T1:   state_nx = S_T2;
            S_T2:   state_nx = S_T3;
            S_T3: begin
                state_nx = S_T4;
                if (EARLY_END && is_nop) last_state = 1'b1;
            end
            S_T4: begin
                if (opcode == OP_HLT) begin
                    state_nx = S_HALT;
                end else begin
                    state_nx = S_T5;
                    if (EARLY_END && (opcode == OP_JMP || opcode == OP_OUT))
                        last_state = 1'b1;
                end
            end
            S_T5: begin
                state_nx = S_T6;
                if (EARLY_END && (opcode == OP_LDA || opcode == OP_STA))
                    last_state = 1'b1;
            end
            S_T6:   last_state = 1'b1;
            S_HALT: state_nx = S_HALT;
            default: state_nx = S_IDLE;
        endcase
        // run only matters at instruction boundaries
        if (last_state) state_nx = run ? S_T1 : S_IDLE;
    end

    always_comb begin
        pc_clr         = ~clr_bar;
        load_pc        = 1'b0;
        pc_inc         = 1'b0;
        enable_pc      = 1'b0;
        load_mar_bar   = 1'b1;
        ram_read_bar   = 1'b1;
        ram_write_bar  = 1'b1;
        enable_ram_bar = 1'b1;
        load_ir_bar    = 1'b1;
        enable_ir_bar  = 1'b1;
        load_a_bar     = 1'b1;
        enable_a_bar   = 1'b1;
        load_b_bar     = 1'b1;
        enable_b_bar   = 1'b1;
        add_sub_bar    = 1'b1;
        enable_alu_bar = 1'b1;
        load_out_bar   = 1'b1;
        t_state        = '0;
        halted         = 1'b0;
        // Gated by clr_bar so no control pulse outlives the reset edge,
        // even transiently before the state register clears.
        if (clr_bar) begin
            case (state)
                S_T1: begin
                    t_state      = 6'b000001;
                    enable_pc    = 1'b1;
                    load_mar_bar = 1'b0;
                end
                S_T2: begin
                    t_state = 6'b000010;
                    pc_inc  = 1'b1;
                end
                S_T3: begin
                    t_state        = 6'b000100;
                    ram_read_bar   = 1'b0;
                    enable_ram_bar = 1'b0;
                    load_ir_bar    = 1'b0;
                end
                S_T4: begin
                    t_state = 6'b001000;
                    if (opcode == OP_LDA || opcode == OP_ADD ||
                        opcode == OP_SUB || opcode == OP_STA) begin
                        enable_ir_bar = 1'b0;
                        load_mar_bar  = 1'b0;
                    end else if (opcode == OP_JMP) begin
                        enable_ir_bar = 1'b0;
                        load_pc       = 1'b1;
                    end else if (opcode == OP_OUT) begin
                        enable_a_bar = 1'b0;
                        load_out_bar = 1'b0;
                    end
                end
                S_T5: begin
                    t_state = 6'b010000;
                    if (opcode == OP_LDA) begin
                        ram_read_bar   = 1'b0;
                        enable_ram_bar = 1'b0;
                        load_a_bar     = 1'b0;
                    end else if (opcode == OP_ADD || opcode == OP_SUB) begin
                        ram_read_bar   = 1'b0;
                        enable_ram_bar = 1'b0;
                        load_b_bar     = 1'b0;
                    end else if (opcode == OP_STA) begin
                        enable_a_bar  = 1'b0;
                        ram_write_bar = 1'b0;
                    end
                end
                S_T6: begin
                    t_state = 6'b100000;
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        enable_alu_bar = 1'b0;
                        load_a_bar     = 1'b0;
                        add_sub_bar    = (opcode == OP_ADD);
                    end
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//   Two instances: u0 with EARLY_END = 0, u1 with EARLY_END = 1. Expected
//   per-cycle control words are queued by the stimulus; a monitor pops and
//   compares on each rising edge (state changes on falling edges).
//   Control word bit order: pc_clr, load_pc, pc_inc, enable_pc, load_mar_bar,
//   ram_read_bar, ram_write_bar, enable_ram_bar, load_ir_bar, enable_ir_bar,
//   load_a_bar, enable_a_bar, load_b_bar, enable_b_bar, add_sub_bar,
//   enable_alu_bar, load_out_bar. Expected = idle word XOR asserted-signal mask.
module tb_control_sequencer;

    localparam logic [16:0] IDLE_W = 17'h01FFF;
    localparam logic [16:0] M_PCCLR = 17'h1_0000, M_LDPC = 17'h0_8000,
                            M_INC   = 17'h0_4000, M_EPC  = 17'h0_2000,
                            M_MAR   = 17'h0_1000, M_RD   = 17'h0_0800,
                            M_WR    = 17'h0_0400, M_ERAM = 17'h0_0200,
                            M_LIR   = 17'h0_0100, M_EIR  = 17'h0_0080,
                            M_LA    = 17'h0_0040, M_EA   = 17'h0_0020,
                            M_LB    = 17'h0_0010, M_EB   = 17'h0_0008,
                            M_SUB   = 17'h0_0004, M_EALU = 17'h0_0002,
                            M_LOUT  = 17'h0_0001;

    localparam logic [3:0] LDA = 4'b0000, ADD = 4'b0001, SUB = 4'b0010,
                           STA = 4'b0011, JMP = 4'b0100, OUTP = 4'b1110,
                           HLT = 4'b1111, NOP = 4'b0111;

    typedef struct {
        bit          sel;
        logic [23:0] word;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk;
    logic       c0, r0, c1, r1;
    logic [3:0] op0, op1;

    logic pc_clr0, load_pc0, pc_inc0, enable_pc0, load_mar_bar0, ram_read_bar0,
          ram_write_bar0, enable_ram_bar0, load_ir_bar0, enable_ir_bar0,
          load_a_bar0, enable_a_bar0, load_b_bar0, enable_b_bar0, add_sub_bar0,
          enable_alu_bar0, load_out_bar0, halted0;
    logic pc_clr1, load_pc1, pc_inc1, enable_pc1, load_mar_bar1, ram_read_bar1,
          ram_write_bar1, enable_ram_bar1, load_ir_bar1, enable_ir_bar1,
          load_a_bar1, enable_a_bar1, load_b_bar1, enable_b_bar1, add_sub_bar1,
          enable_alu_bar1, load_out_bar1, halted1;
    logic [5:0] t_state0, t_state1;

    control_sequencer #(.EARLY_END(1'b0)) u0 (
        .clk(clk), .clr_bar(c0), .run(r0), .opcode(op0),
        .pc_clr(pc_clr0), .load_pc(load_pc0), .pc_inc(pc_inc0), .enable_pc(enable_pc0),
        .load_mar_bar(load_mar_bar0), .ram_read_bar(ram_read_bar0),
        .ram_write_bar(ram_write_bar0), .enable_ram_bar(enable_ram_bar0),
        .load_ir_bar(load_ir_bar0), .enable_ir_bar(enable_ir_bar0),
        .load_a_bar(load_a_bar0), .enable_a_bar(enable_a_bar0),
        .load_b_bar(load_b_bar0), .enable_b_bar(enable_b_bar0),
        .add_sub_bar(add_sub_bar0), .enable_alu_bar(enable_alu_bar0),
        .load_out_bar(load_out_bar0), .t_state(t_state0), .halted(halted0)
    );

    control_sequencer #(.EARLY_END(1'b1)) u1 (
        .clk(clk), .clr_bar(c1), .run(r1), .opcode(op1),
        .pc_clr(pc_clr1), .load_pc(load_pc1), .pc_inc(pc_inc1), .enable_pc(enable_pc1),
        .load_mar_bar(load_mar_bar1), .ram_read_bar(ram_read_bar1),
        .ram_write_bar(ram_write_bar1), .enable_ram_bar(enable_ram_bar1),
        .load_ir_bar(load_ir_bar1), .enable_ir_bar(enable_ir_bar1),
        .load_a_bar(load_a_bar1), .enable_a_bar(enable_a_bar1),
        .load_b_bar(load_b_bar1), .enable_b_bar(enable_b_bar1),
        .add_sub_bar(add_sub_bar1), .enable_alu_bar(enable_alu_bar1),
        .load_out_bar(load_out_bar1), .t_state(t_state1), .halted(halted1)
    );

    logic [23:0] w0, w1;
    assign w0 = {pc_clr0, load_pc0, pc_inc0, enable_pc0, load_mar_bar0, ram_read_bar0,
                 ram_write_bar0, enable_ram_bar0, load_ir_bar0, enable_ir_bar0,
                 load_a_bar0, enable_a_bar0, load_b_bar0, enable_b_bar0,
                 add_sub_bar0, enable_alu_bar0, load_out_bar0, t_state0, halted0};
    assign w1 = {pc_clr1, load_pc1, pc_inc1, enable_pc1, load_mar_bar1, ram_read_bar1,
                 ram_write_bar1, enable_ram_bar1, load_ir_bar1, enable_ir_bar1,
                 load_a_bar1, enable_a_bar1, load_b_bar1, enable_b_bar1,
                 add_sub_bar1, enable_alu_bar1, load_out_bar1, t_state1, halted1};

    logic [5:0] bus0, bus1;
    assign bus0 = {enable_pc0, ~enable_ram_bar0, ~enable_ir_bar0, ~enable_a_bar0,
                   ~enable_b_bar0, ~enable_alu_bar0};
    assign bus1 = {enable_pc1, ~enable_ram_bar1, ~enable_ir_bar1, ~enable_a_bar1,
                   ~enable_b_bar1, ~enable_alu_bar1};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: invariants on both instances every cycle, then scoreboard pop.
    always @(posedge clk) begin
        exp_t e;
        logic [23:0] act;
        checks = checks + 4;
        if ($countones(bus0) > 1) begin
            errors++;
            $display("FAIL bus_onehot dut0: drivers=%b required at most one", bus0);
        end
        if ($countones(bus1) > 1) begin
            errors++;
            $display("FAIL bus_onehot dut1: drivers=%b required at most one", bus1);
        end
        if (!ram_read_bar0 && !ram_write_bar0) begin
            errors++;
            $display("FAIL rd_wr_excl dut0: read_bar=0 write_bar=0 required not both 0");
        end
        if (!ram_read_bar1 && !ram_write_bar1) begin
            errors++;
            $display("FAIL rd_wr_excl dut1: read_bar=0 write_bar=0 required not both 0");
        end
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            act = e.sel ? w1 : w0;
            checks++;
            if (act !== e.word) begin
                errors++;
                $display("FAIL %s dut%0d: got ctrl=%h t=%b h=%b, expected ctrl=%h t=%b h=%b",
                         e.name, e.sel, act[23:7], act[6:1], act[0],
                         e.word[23:7], e.word[6:1], e.word[0]);
            end
        end
    end

    // Queue the word expected at the coming rising edge, then advance to
    // just after that edge. Inputs set before a call take effect at the
    // falling edge in between.
    task automatic step(input bit sel, input logic [16:0] m, input logic [5:0] ts,
                        input logic h, input string nm);
        exp_t e;
        e.sel  = sel;
        e.word = {IDLE_W ^ m, ts, h};
        e.name = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Fetch T1..T3; opcode changes after T1 is entered so the previous
    // instruction's end decision is not disturbed.
    task automatic fetch(input bit sel, input logic [3:0] op);
        step(sel, M_EPC | M_MAR, 6'b000001, 1'b0, "t1_fetch");
        if (sel) op1 = op; else op0 = op;
        step(sel, M_INC, 6'b000010, 1'b0, "t2_inc");
        step(sel, M_RD | M_ERAM | M_LIR, 6'b000100, 1'b0, "t3_ir");
    endtask

    initial begin
        c0 = 1'b0; c1 = 1'b0; r0 = 1'b0; r1 = 1'b0; op0 = '0; op1 = '0;
        @(posedge clk);
        #1;
        // reset and idle
        step(0, M_PCCLR, 6'b0, 1'b0, "reset");
        step(0, M_PCCLR, 6'b0, 1'b0, "reset");
        c0 = 1'b1;
        repeat (5) step(0, '0, 6'b0, 1'b0, "idle_run0");

        // EARLY_END = 0: LDA, ADD, SUB (run dropped mid-SUB)
        r0 = 1'b1;
        fetch(0, LDA);
        step(0, M_EIR | M_MAR, 6'b001000, 1'b0, "lda_t4");
        step(0, M_RD | M_ERAM | M_LA, 6'b010000, 1'b0, "lda_t5");
        step(0, '0, 6'b100000, 1'b0, "lda_t6_nop");
        fetch(0, ADD);
        step(0, M_EIR | M_MAR, 6'b001000, 1'b0, "add_t4");
        step(0, M_RD | M_ERAM | M_LB, 6'b010000, 1'b0, "add_t5");
        step(0, M_EALU | M_LA, 6'b100000, 1'b0, "add_t6");
        fetch(0, SUB);
        r0 = 1'b0;
        step(0, M_EIR | M_MAR, 6'b001000, 1'b0, "sub_t4");
        step(0, M_RD | M_ERAM | M_LB, 6'b010000, 1'b0, "sub_t5");
        step(0, M_EALU | M_LA | M_SUB, 6'b100000, 1'b0, "sub_t6");
        step(0, '0, 6'b0, 1'b0, "idle_after_sub");
        step(0, '0, 6'b0, 1'b0, "idle_after_sub");

        // STA, then asynchronous clear in the middle of T5
        r0 = 1'b1;
        fetch(0, STA);
        step(0, M_EIR | M_MAR, 6'b001000, 1'b0, "sta_t4");
        step(0, M_EA | M_WR, 6'b010000, 1'b0, "sta_t5");
        c0 = 1'b0;
        #1;
        checks++;
        if (w0 !== {IDLE_W ^ M_PCCLR, 6'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_clr dut0: got ctrl=%h t=%b h=%b, expected ctrl=%h t=000000 h=0",
                     w0[23:7], w0[6:1], w0[0], IDLE_W ^ M_PCCLR);
        end
        @(posedge clk);
        #1;
        step(0, M_PCCLR, 6'b0, 1'b0, "clr_hold");
        r0 = 1'b0;
        c0 = 1'b1;
        step(0, '0, 6'b0, 1'b0, "idle_after_clr");

        // HLT with EARLY_END = 0, run toggled while halted
        r0 = 1'b1;
        fetch(0, HLT);
        step(0, '0, 6'b001000, 1'b0, "hlt_t4");
        for (int i = 0; i < 10; i++) begin
            r0 = ~r0;
            step(0, '0, 6'b0, 1'b1, "halt_sticky");
        end
        c0 = 1'b0;
        step(0, M_PCCLR, 6'b0, 1'b0, "halt_clr");
        r0 = 1'b0;
        c0 = 1'b1;
        step(0, '0, 6'b0, 1'b0, "idle_after_halt");

        // EARLY_END = 1: JMP, OUT, LDA, ADD, STA, NOP, HLT back to back
        c1 = 1'b1;
        step(1, '0, 6'b0, 1'b0, "idle1");
        r1 = 1'b1;
        fetch(1, JMP);
        step(1, M_EIR | M_LDPC, 6'b001000, 1'b0, "jmp_t4");
        fetch(1, OUTP);
        step(1, M_EA | M_LOUT, 6'b001000, 1'b0, "out_t4");
        fetch(1, LDA);
        step(1, M_EIR | M_MAR, 6'b001000, 1'b0, "ee_lda_t4");
        step(1, M_RD | M_ERAM | M_LA, 6'b010000, 1'b0, "ee_lda_t5");
        fetch(1, ADD);
        step(1, M_EIR | M_MAR, 6'b001000, 1'b0, "ee_add_t4");
        step(1, M_RD | M_ERAM | M_LB, 6'b010000, 1'b0, "ee_add_t5");
        step(1, M_EALU | M_LA, 6'b100000, 1'b0, "ee_add_t6");
        fetch(1, STA);
        step(1, M_EIR | M_MAR, 6'b001000, 1'b0, "ee_sta_t4");
        step(1, M_EA | M_WR, 6'b010000, 1'b0, "ee_sta_t5");
        fetch(1, NOP);
        fetch(1, HLT);
        step(1, '0, 6'b001000, 1'b0, "ee_hlt_t4");
        for (int i = 0; i < 4; i++) begin
            r1 = ~r1;
            step(1, '0, 6'b0, 1'b1, "ee_halt_sticky");
        end
        c1 = 1'b0;
        step(1, M_PCCLR, 6'b0, 1'b0, "ee_halt_clr");
        r1 = 1'b0;
        c1 = 1'b1;
        step(1, '0, 6'b0, 1'b0, "ee_idle_end");

        repeat (3) @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
